cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 152 +++++++++++++++
 tb/tb_cbus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_arbiter (with package cbus_pkg)
//  Description : Burst-locked N:1 cache-bus arbiter. A granted master keeps
//                the memory port until a response beat with last=1 is
//                accepted; one IDLE cycle always separates two grants.
//                Optional macro CBUS_ARB_ROUND_ROBIN_EN selects rotating
//                priority; without it, the lowest valid index wins.
//  Revision    : 1.0 - initial release
// ============================================================================

package cbus_pkg;

    // Burst length encoding carried with each request
    typedef enum logic [1:0] {
        MLEN1  = 2'd0,
        MLEN4  = 2'd1,
        MLEN8  = 2'd2,
        MLEN16 = 2'd3
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        cbus_len_t   len;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;

endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  cbus_req_t  [NUM_CH-1:0] ireqs,
    output cbus_resp_t [NUM_CH-1:0] iresps,
    output cbus_req_t               oreq,
    input  cbus_resp_t              oresp,
    output logic       [CH_W-1:0]   owner,
    output logic                    busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [CH_W-1:0] r_owner;
    logic [CH_W-1:0] w_sel;
    logic            w_any;
    logic            w_done;

    // A burst completes only on an accepted beat flagged as the last one
    assign w_done = oresp.ready & oresp.last;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] r_rr_ptr;
    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_cand;

    // Rotating search from r_rr_ptr; scanning downward lets the nearest valid channel win
    always_comb begin
        w_sel  = '0;
        w_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (CH_W + 1)'(k);
            if (w_sum >= (CH_W + 1)'(NUM_CH)) begin
                w_sum = w_sum - (CH_W + 1)'(NUM_CH);
            end
            w_cand = w_sum[CH_W-1:0];
            if (ireqs[w_cand].valid) begin
                w_sel = w_cand;
                w_any = 1'b1;
            end
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest valid index selected
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ireqs[k].valid) begin
                w_sel = CH_W'(k);
                w_any = 1'b1;
            end
        end
    end
`endif

    // Grant/burst FSM: owner is captured at grant and held for the whole burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_sel;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state  <= ST_IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                        // Explicit wrap keeps the pointer legal for non-power-of-2 channel counts
                        r_rr_ptr <= (r_owner == c_last_ch) ? '0 : r_owner + 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == ST_BUSY);
    assign owner = r_owner;

    // Route the owner's request out and the memory response back; everything is quiet when idle
    always_comb begin
        oreq   = '0;
        iresps = '0;
        if (busy) begin
            oreq             = ireqs[r_owner];
            iresps[r_owner]  = oresp;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cbus_arbiter
//  Description : Scoreboard bench for cbus_arbiter. Two instances (2 and 3
//                channels) share one stimulus set selected by 'sel'; expected
//                grants are queued by the stimulus and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;
    import cbus_pkg::*;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    logic sel;
    logic stray;

    cbus_req_t  [2:0] req;
    cbus_req_t  [1:0] ireqs_a;
    cbus_req_t  [2:0] ireqs_b;
    cbus_resp_t [1:0] iresps_a;
    cbus_resp_t [2:0] iresps_b;
    cbus_req_t        oreq_a;
    cbus_req_t        oreq_b;
    cbus_resp_t       oresp;
    logic             owner_a;
    logic [1:0]       owner_b;
    logic             busy_a;
    logic             busy_b;

    assign ireqs_a = sel ? '0 : req[1:0];
    assign ireqs_b = sel ? req : '0;

    cbus_arbiter #(.NUM_CH(2)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs_a),
        .iresps (iresps_a),
        .oreq   (oreq_a),
        .oresp  (oresp),
        .owner  (owner_a),
        .busy   (busy_a)
    );

    cbus_arbiter #(.NUM_CH(3)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs_b),
        .iresps (iresps_b),
        .oreq   (oreq_b),
        .oresp  (oresp),
        .owner  (owner_b),
        .busy   (busy_b)
    );

    // Active-instance view used by the responder and the monitor
    logic             m_busy;
    logic [1:0]       m_owner;
    cbus_req_t        m_oreq;
    cbus_resp_t [2:0] m_iresps;

    assign m_busy   = sel ? busy_b : busy_a;
    assign m_owner  = sel ? owner_b : {1'b0, owner_a};
    assign m_oreq   = sel ? oreq_b : oreq_a;
    assign m_iresps = sel ? iresps_b : {{$bits(cbus_resp_t){1'b0}}, iresps_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int grants_seen = 0;
    int cycle       = 0;
    int beat        = 0;

    typedef struct {
        int owner;
        int beats;   // 0: burst is abandoned, length not checked
        int gap;     // idle cycles before this grant, -1: not checked
    } exp_t;

    exp_t exp_q[$];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int nbeats(cbus_len_t len);
        case (len)
            MLEN1:   return 1;
            MLEN4:   return 4;
            MLEN8:   return 8;
            default: return 16;
        endcase
    endfunction

    function automatic cbus_req_t mk(logic [31:0] addr, cbus_len_t len);
        cbus_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.addr  = addr;
        r.len   = len;
        r.wdata = addr ^ 32'h5A5A_5A5A;
        return r;
    endfunction

    // Memory responder: ready every cycle of a burst, last on the final beat
    logic drove;
    always @(negedge clk) begin
        if (reset) begin
            beat  = 0;
            drove = 1'b0;
            oresp = '0;
        end else begin
            if (drove && oresp.ready) beat = oresp.last ? 0 : beat + 1;
            if (m_busy) begin
                oresp.ready = 1'b1;
                oresp.last  = (beat == nbeats(m_oreq.len) - 1);
                oresp.rdata = 32'hB000_0000 + 32'(beat);
                drove       = 1'b1;
            end else if (stray) begin
                oresp.ready = 1'b1;
                oresp.last  = 1'b1;
                oresp.rdata = 32'hDEAD_BEEF;
                drove       = 1'b0;
            end else begin
                oresp = '0;
                drove = 1'b0;
            end
        end
    end

    // Monitor: pops the expected grant on each grant start and checks routing every cycle
    int               cur_owner = 0;
    int               exp_beats = 0;
    int               busy_len  = 0;
    int               end_cycle = 0;
    logic             prev_busy = 1'b0;
    exp_t             e;
    cbus_resp_t [2:0] exp_r;

    always @(negedge clk) begin
        #1;
        cycle++;
        check("other_idle", sel ? busy_a : busy_b, 0);
        if (!m_busy) begin
            check("idle_oreq", m_oreq, 0);
            check("idle_iresps", m_iresps, 0);
            if (prev_busy) begin
                if (exp_beats != 0) check("burst_len", busy_len, exp_beats);
                end_cycle = cycle;
            end
        end else begin
            if (!prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: got owner %0d expected no grant", m_owner);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_owner", m_owner, e.owner);
                    cur_owner = e.owner;
                    exp_beats = e.beats;
                    if (e.gap >= 0) check("grant_gap", cycle - end_cycle, e.gap);
                end
                busy_len = 0;
                grants_seen++;
            end
            busy_len++;
            check("oreq_route", m_oreq, req[cur_owner]);
            exp_r            = '0;
            exp_r[cur_owner] = oresp;
            check("iresp_route", m_iresps, exp_r);
        end
        prev_busy = m_busy;
    end

    task automatic wait_grants(int target, int budget);
        int k = 0;
        while (grants_seen < target && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("grant_count", grants_seen, target);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (m_busy && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("idle_reached", m_busy, 0);
    endtask

    task automatic wait_beat(int b, int budget);
        int k = 0;
        while (!(m_busy && beat == b) && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("beat_reached", beat, b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        sel   = 1'b0;
        stray = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy_a", busy_a, 0);
        check("rst_owner_a", owner_a, 0);
        check("rst_oreq_a", oreq_a, 0);
        check("rst_iresps_a", iresps_a, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_owner_b", owner_b, 0);
        reset = 1'b0;

        // Single master, 4-beat burst on ch1; ch1 drops valid right after grant
        req[1] = mk(32'h8000_0000, MLEN4);
        exp_q.push_back('{owner: 1, beats: 4, gap: -1});
        wait_grants(1, 1);
        check("t1_owner", owner_a, 1);
        check("t1_addr", oreq_a.addr, 32'h8000_0000);
        req[1].valid = 1'b0;
        wait_idle(10);

        // Response beats while idle are dropped
        stray = 1'b1;
        repeat (2) begin @(negedge clk); #2; end
        stray = 1'b0;
        check("stray_busy", busy_a, 0);
        @(negedge clk); #2;

        // Contention with single-beat bursts
        base   = grants_seen;
        req[0] = mk(32'h0000_0100, MLEN1);
        req[1] = mk(32'h0000_0200, MLEN1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{owner: (RR_EN ? (i % 2) : 0), beats: 1, gap: (i == 0) ? -1 : 1});
        end
        wait_grants(base + 4, 20);
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
        wait_idle(5);

        // Burst lock: ch1 arrives during ch0's 16-beat burst
        base   = grants_seen;
        req[0] = mk(32'h0000_1000, MLEN16);
        exp_q.push_back('{owner: 0, beats: 16, gap: -1});
        wait_grants(base + 1, 3);
        req[0].valid = 1'b0;
        wait_beat(2, 10);
        req[1] = mk(32'h0000_2000, MLEN1);
        exp_q.push_back('{owner: 1, beats: 1, gap: 1});
        wait_grants(base + 2, 30);
        req[1].valid = 1'b0;
        wait_idle(5);

        // Reset in the middle of an 8-beat burst on ch1
        base   = grants_seen;
        req[1] = mk(32'h0000_3000, MLEN8);
        exp_q.push_back('{owner: 1, beats: 0, gap: -1});
        wait_grants(base + 1, 3);
        req[1].valid = 1'b0;
        wait_beat(1, 10);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", oreq_a.valid, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_owner", owner_a, 0);
        check("mid_rst_iresps", iresps_a, 0);
        @(negedge clk); #2;
        reset  = 1'b0;
        req[1] = mk(32'h0000_4000, MLEN4);
        exp_q.push_back('{owner: 1, beats: 4, gap: -1});
        wait_grants(base + 2, 1);
        check("post_rst_owner", owner_a, 1);
        req[1].valid = 1'b0;
        wait_idle(10);

        // Three channels: ch2 alone, then ch0 and ch1 contending
        @(negedge clk); #2;
        sel    = 1'b1;
        base   = grants_seen;
        req    = '0;
        req[2] = mk(32'h0000_5000, MLEN1);
        exp_q.push_back('{owner: 2, beats: 1, gap: -1});
        wait_grants(base + 1, 3);
        req[2].valid = 1'b0;
        wait_idle(5);
        req[0] = mk(32'h0000_6000, MLEN1);
        req[1] = mk(32'h0000_7000, MLEN1);
        exp_q.push_back('{owner: 0, beats: 1, gap: -1});
        exp_q.push_back('{owner: (RR_EN ? 1 : 0), beats: 1, gap: 1});
        wait_grants(base + 3, 10);
        req[0].valid = 1'b0;
        req[1].valid = 1'b0;
        wait_idle(5);

        repeat (3) begin @(negedge clk); #2; end
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
